regfile_wb_arbiter: RTL

Shares the register file's single write port between two writeback requesters. Requester A is the main pipeline WB stage. Requester B is a multi-cycle source such as the mult/div unit or a late load return. A has fixed priority, and a starvation counter periodically forces a B grant. The block drives the register file's writeReg/writeData/writeEnable through registered outputs and drops writes to $zero.

---
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the pipeline WB stage (A)
// and a multi-cycle writeback source (B), with a starvation override that forces B through.
module regfile_wb_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int ZERO_GUARD   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0] b_data,
   output logic [ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              writeEnable,
   output logic              b_forced
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {
      A_PRIO  = 1'b0,
      B_FORCE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        waitCnt_q, waitCnt_d;
   logic [ADDR_W-1:0] writeReg_q, writeReg_d;
   logic [DATA_W-1:0] writeData_q, writeData_d;
   logic              writeEnable_q, writeEnable_d;
   logic              aReady, bReady;
   logic              aAccept, bAccept;

   // Readies are forced low while reset is held so nothing is consumed during reset.
   always_comb begin
      aReady = 1'b0;
      bReady = 1'b0;
      if (rst_n) begin
         if (state_q == A_PRIO) begin
            aReady = 1'b1;
            bReady = !a_valid;
         end else begin
            bReady = 1'b1;
         end
      end
   end

   assign aAccept = a_valid && aReady;
   assign bAccept = b_valid && bReady;

   // B_FORCE always lasts one cycle: either B is taken or B vanished, and both return to A_PRIO.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      case (state_q)
         A_PRIO: begin
            if (a_valid && b_valid) begin
               if (({1'b0, waitCnt_q} + 5'd1) >= {1'b0, LIMIT}) begin
                  state_d   = B_FORCE;
                  waitCnt_d = LIMIT;
               end else begin
                  waitCnt_d = waitCnt_q + 4'd1;
               end
            end else begin
               waitCnt_d = 4'd0;
            end
         end
         B_FORCE: begin
            state_d   = A_PRIO;
            waitCnt_d = 4'd0;
         end
         default: begin
            state_d   = A_PRIO;
            waitCnt_d = 4'd0;
         end
      endcase
   end

   // Guarded writes to register 0 still update address/data but never raise the enable.
   always_comb begin
      writeReg_d    = writeReg_q;
      writeData_d   = writeData_q;
      writeEnable_d = 1'b0;
      if (aAccept) begin
         writeReg_d    = a_reg;
         writeData_d   = a_data;
         writeEnable_d = !((ZERO_GUARD != 0) && (a_reg == '0));
      end else if (bAccept) begin
         writeReg_d    = b_reg;
         writeData_d   = b_data;
         writeEnable_d = !((ZERO_GUARD != 0) && (b_reg == '0));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= A_PRIO;
         waitCnt_q     <= 4'd0;
         writeReg_q    <= '0;
         writeData_q   <= '0;
         writeEnable_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         waitCnt_q     <= waitCnt_d;
         writeReg_q    <= writeReg_d;
         writeData_q   <= writeData_d;
         writeEnable_q <= writeEnable_d;
      end
   end

   assign a_ready     = aReady;
   assign b_ready     = bReady;
   assign writeReg    = writeReg_q;
   assign writeData   = writeData_q;
   assign writeEnable = writeEnable_q;
   assign b_forced    = (state_q == B_FORCE);

endmodule
